// File: rtl/f1_lights_timer.sv
// F1 start-light reaction timer: lamp sequence, LFSR hold, reaction capture.
// Ports: i_clk, i_rst (sync, active high), i_en (freeze when low),
//   i_N (tick period - 1), i_trigger, i_react;
//   o_lights, o_cmd_seq, o_cmd_delay, o_react_time, o_react_vld,
//   o_jump_start.
module f1_lights_timer #(
    parameter int WIDTH      = 16,
    parameter int NUM_LIGHTS = 8,
    parameter int DELAY_W    = 7,
    parameter int MIN_HOLD   = 4,
    parameter int RT_W       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [WIDTH-1:0]      i_N,
    input  logic                  i_trigger,
    input  logic                  i_react,
    output logic [NUM_LIGHTS-1:0] o_lights,
    output logic                  o_cmd_seq,
    output logic                  o_cmd_delay,
    output logic [RT_W-1:0]       o_react_time,
    output logic                  o_react_vld,
    output logic                  o_jump_start
);

    localparam int HOLD_MAX = MIN_HOLD + (1 << DELAY_W) - 1;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEQ,
        S_HOLD,
        S_GO,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_tick_cnt;
    logic [WIDTH-1:0]      w_tick_cnt_nxt;
    logic [NUM_LIGHTS-1:0] r_lights;
    logic [NUM_LIGHTS-1:0] w_lights_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_cnt_nxt;
    logic [RT_W-1:0]       r_rt_cnt;
    logic [RT_W-1:0]       w_rt_cnt_nxt;
    logic [RT_W-1:0]       r_react_time;
    logic [RT_W-1:0]       w_react_time_nxt;
    logic                  r_react_vld;
    logic                  w_react_vld_nxt;
    logic [DELAY_W-1:0]    r_lfsr;
    logic                  w_fb;
    logic                  w_tick;

    generate
        if (NUM_LIGHTS < 2 || NUM_LIGHTS > 32) begin : g_bad_lights
            $error("NUM_LIGHTS must be in 2..32");
        end
        if (MIN_HOLD < 1) begin : g_bad_hold
            $error("MIN_HOLD must be at least 1");
        end
        if (DELAY_W == 7) begin : g_fb7
            assign w_fb = r_lfsr[6] ^ r_lfsr[5];
        end else if (DELAY_W == 8) begin : g_fb8
            assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
        end else if (DELAY_W == 16) begin : g_fb16
            assign w_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
        end else begin : g_bad_delay
            $error("DELAY_W must be 7, 8 or 16");
            assign w_fb = 1'b0;
        end
    endgenerate

    assign w_tick = (r_tick_cnt == i_N);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_lights     <= '0;
            r_hold_cnt   <= '0;
            r_rt_cnt     <= '0;
            r_react_time <= '0;
            r_react_vld  <= 1'b0;
            r_lfsr       <= DELAY_W'(1);
        end else if (i_en) begin
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_lights     <= w_lights_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_rt_cnt     <= w_rt_cnt_nxt;
            r_react_time <= w_react_time_nxt;
            r_react_vld  <= w_react_vld_nxt;
            r_lfsr       <= {r_lfsr[DELAY_W-2:0], w_fb};
        end else begin
            // A frozen cycle must not stretch the capture pulse.
            r_react_vld  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_cnt_nxt   = r_tick_cnt;
        w_lights_nxt     = r_lights;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_rt_cnt_nxt     = r_rt_cnt;
        w_react_time_nxt = r_react_time;
        w_react_vld_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_lights_nxt = '0;
                if (i_trigger) begin
                    w_state_nxt    = S_SEQ;
                    w_tick_cnt_nxt = '0;
                end
            end
            S_SEQ: begin
                if (i_react) begin
                    w_state_nxt  = S_FAULT;
                    w_lights_nxt = '0;
                end else if (w_tick) begin
                    w_tick_cnt_nxt = '0;
                    w_lights_nxt   = {r_lights[NUM_LIGHTS-2:0], 1'b1};
                    // Hold starts on the tick that lights the last lamp.
                    if (&r_lights[NUM_LIGHTS-2:0]) begin
                        w_state_nxt    = S_HOLD;
                        w_hold_cnt_nxt = HOLD_W'(MIN_HOLD) + HOLD_W'(r_lfsr);
                    end
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt + WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (i_react) begin
                    w_state_nxt  = S_FAULT;
                    w_lights_nxt = '0;
                end else if (r_hold_cnt == HOLD_W'(1)) begin
                    w_state_nxt  = S_GO;
                    w_lights_nxt = '0;
                    w_rt_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            S_GO: begin
                w_lights_nxt = '0;
                if (r_rt_cnt != '1) begin
                    w_rt_cnt_nxt = r_rt_cnt + RT_W'(1);
                end
                if (i_react) begin
                    w_state_nxt      = S_DONE;
                    w_react_time_nxt = r_rt_cnt;
                    w_react_vld_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                if (!i_trigger) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                w_lights_nxt = '0;
                if (!i_trigger) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_lights_nxt = '0;
            end
        endcase
    end

    assign o_lights     = r_lights;
    assign o_cmd_seq    = (r_state == S_SEQ);
    assign o_cmd_delay  = (r_state == S_HOLD);
    assign o_react_time = r_react_time;
    assign o_react_vld  = r_react_vld;
    assign o_jump_start = (r_state == S_FAULT);

endmodule

// File: tb/tb_f1_lights_timer.sv
// Bench for f1_lights_timer: two instances (RT_W 16 and 4) on shared stimulus,
// timeline model predicts events, negedge monitor pops and compares.
module tb_f1_lights_timer;

    localparam int NL   = 5;
    localparam int MINH = 4;

    typedef struct {
        int v;
        int e;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        trigger;
    logic        react;
    logic [15:0] n_val;

    logic [NL-1:0] lights_a, lights_b;
    logic          seq_a, seq_b, dly_a, dly_b;
    logic [15:0]   rt_a;
    logic [3:0]    rt_b;
    logic          vld_a, vld_b, js_a, js_b;

    always #5 clk = ~clk;

    f1_lights_timer #(
        .WIDTH(16), .NUM_LIGHTS(NL), .DELAY_W(7), .MIN_HOLD(MINH), .RT_W(16)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_N(n_val),
        .i_trigger(trigger), .i_react(react),
        .o_lights(lights_a), .o_cmd_seq(seq_a), .o_cmd_delay(dly_a),
        .o_react_time(rt_a), .o_react_vld(vld_a), .o_jump_start(js_a)
    );

    f1_lights_timer #(
        .WIDTH(16), .NUM_LIGHTS(NL), .DELAY_W(7), .MIN_HOLD(MINH), .RT_W(4)
    ) u_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_N(n_val),
        .i_trigger(trigger), .i_react(react),
        .o_lights(lights_b), .o_cmd_seq(seq_b), .o_cmd_delay(dly_b),
        .o_react_time(rt_b), .o_react_vld(vld_b), .o_jump_start(js_b)
    );

    int errors = 0;
    int checks = 0;

    ev_t q_lights[$];
    ev_t q_rt[$];
    ev_t q_fault[$];
    int  q_seq[$];
    int  q_hold[$];

    // Reference timeline: j counts enabled edges since the run started.
    bit m_bits[$];
    bit m_run  = 0;
    int m_post = 0;
    int m_edge = 0;
    int m_j, m_w, m_wT, m_T, m_H, m_G, m_hfrz, m_n;
    int m_lamps   = 0;
    int m_last_rt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    function automatic ev_t mk(input int v, input int e);
        ev_t x;
        x.v = v;
        x.e = e;
        return x;
    endfunction

    // LFSR seen as a bit stream: s[k+7] = s[k] ^ s[k+1], value = last 7 bits.
    function automatic int lfsr_val();
        int v = 0;
        foreach (m_bits[i]) v = (v << 1) | int'(m_bits[i]);
        return v;
    endfunction

    task automatic lfsr_reset();
        m_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endtask

    task automatic lfsr_adv();
        m_bits.push_back(m_bits[0] ^ m_bits[1]);
        void'(m_bits.pop_front());
    endtask

    task automatic model_edge(input bit t, input bit r, input bit e,
                              input bit rs);
        int lv;
        m_edge++;
        if (rs) begin
            if (m_run) begin
                m_w++;
                if (m_j < m_T) q_seq.push_back(m_w);
                else if (m_j < m_G) q_hold.push_back(m_w - m_wT);
                if (m_lamps != 0) q_lights.push_back(mk(0, m_edge));
            end
            m_run     = 0;
            m_post    = 0;
            m_lamps   = 0;
            m_last_rt = 0;
            lfsr_reset();
            return;
        end
        if (m_run) m_w++;
        if (!e) begin
            if (m_run && m_j >= m_T && m_j < m_G) m_hfrz++;
            return;
        end
        lv = lfsr_val();
        lfsr_adv();
        if (m_run) begin
            m_j++;
            if (r && m_j <= m_G) begin
                if (m_j <= m_T) q_seq.push_back(m_w);
                else q_hold.push_back(m_w - m_wT);
                if (m_lamps != 0) q_lights.push_back(mk(0, m_edge));
                m_lamps = 0;
                q_fault.push_back(mk(m_last_rt, m_edge));
                m_run  = 0;
                m_post = 2;
            end else if (m_j <= m_T) begin
                if (m_j % (m_n + 1) == 0) begin
                    m_lamps = m_j / (m_n + 1);
                    q_lights.push_back(mk((1 << m_lamps) - 1, m_edge));
                end
                if (m_j == m_T) begin
                    m_H    = MINH + lv;
                    m_G    = m_T + m_H;
                    m_wT   = m_w;
                    m_hfrz = 0;
                    q_seq.push_back(m_w);
                end
            end else if (m_j == m_G) begin
                q_hold.push_back(m_H + m_hfrz);
                q_lights.push_back(mk(0, m_edge));
                m_lamps = 0;
            end else if (m_j > m_G && r) begin
                m_last_rt = m_j - m_G - 1;
                q_rt.push_back(mk(m_last_rt, m_edge));
                m_run  = 0;
                m_post = 1;
            end
        end else if (m_post != 0) begin
            if (!t) m_post = 0;
        end else if (t) begin
            m_run  = 1;
            m_j    = 0;
            m_w    = 0;
            m_n    = int'(n_val);
            m_T    = NL * (m_n + 1);
            m_G    = 1 << 30;
            m_hfrz = 0;
        end
    endtask

    task automatic step(input bit t, input bit r, input bit e, input bit rs);
        trigger = t;
        react   = r;
        en      = e;
        rst     = rs;
        @(posedge clk);
        model_edge(t, r, e, rs);
        #1;
    endtask

    task automatic run_to(input int tgt, input bit t);
        for (int k = 0; k < 500 && m_run && m_j < tgt; k++) step(t, 0, 1, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (m_run || m_post != 0); k++)
            step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
    endtask

    // Monitor
    bit            mon_on = 0;
    int            mon_cyc = 0;
    logic [NL-1:0] p_l;
    logic          p_v, p_j;
    int            sl = 0;
    int            hl = 0;
    int            xi;
    ev_t           mev;

    always @(negedge clk) begin
        mon_cyc++;
        if (mon_on) begin
            if (lights_a !== p_l) begin
                if (q_lights.size() == 0) miss("lights_change");
                else begin
                    mev = q_lights.pop_front();
                    chk("lights_a", 32'(lights_a), mev.v);
                    chk("lights_b", 32'(lights_b), mev.v);
                    chk("lights_cycle", mon_cyc, mev.e);
                end
            end
            if (seq_a) sl++;
            else if (sl > 0) begin
                if (q_seq.size() == 0) miss("seq_pulse");
                else begin
                    xi = q_seq.pop_front();
                    chk("seq_len", sl, xi);
                end
                sl = 0;
            end
            if (dly_a) hl++;
            else if (hl > 0) begin
                if (q_hold.size() == 0) miss("hold_pulse");
                else begin
                    xi = q_hold.pop_front();
                    chk("hold_len", hl, xi);
                end
                hl = 0;
            end
            if (p_v) chk("vld_pulse", 32'(vld_a), 0);
            if (vld_a && !p_v) begin
                if (q_rt.size() == 0) miss("react_vld");
                else begin
                    mev = q_rt.pop_front();
                    chk("rt_a", 32'(rt_a), mev.v);
                    chk("rt_b", 32'(rt_b), (mev.v > 15) ? 15 : mev.v);
                    chk("vld_cycle", mon_cyc, mev.e);
                    chk("vld_b", 32'(vld_b), 1);
                end
            end
            if (js_a && !p_j) begin
                if (q_fault.size() == 0) miss("jump_start");
                else begin
                    mev = q_fault.pop_front();
                    chk("fault_rt", 32'(rt_a), mev.v);
                    chk("fault_lights", 32'(lights_a), 0);
                    chk("fault_cycle", mon_cyc, mev.e);
                    chk("fault_b", 32'(js_b), 1);
                end
            end
            p_l = lights_a;
            p_v = vld_a;
            p_j = js_a;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hoff, tlen, rat, rst_at;
        n_val = 16'd3;
        lfsr_reset();
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("rst_lights", 32'(lights_a), 0);
        chk("rst_seq", 32'(seq_a), 0);
        chk("rst_delay", 32'(dly_a), 0);
        chk("rst_rt", 32'(rt_a), 0);
        chk("rst_vld", 32'(vld_a), 0);
        chk("rst_js", 32'(js_a), 0);
        chk("rst_lfsr", 32'(u_dut.r_lfsr), 1);
        p_l    = lights_a;
        p_v    = vld_a;
        p_j    = js_a;
        mon_on = 1;

        // Full run, react on 11th GO cycle
        step(1, 0, 1, 0);
        run_to(m_T, 0);
        run_to(m_G + 10, 0);
        step(0, 1, 1, 0);
        drain();

        // Jump start early in hold, trigger held through FAULT
        step(1, 0, 1, 0);
        run_to(m_T, 1);
        hoff = $urandom_range(0, 3);
        run_to(m_T + hoff, 1);
        step(1, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0);
        drain();

        // React on the final hold cycle
        step(1, 0, 1, 0);
        run_to(m_T, 0);
        run_to(m_G - 1, 0);
        step(0, 1, 1, 0);
        drain();

        // React together with the last tick
        step(1, 0, 1, 0);
        run_to(m_T - 1, 0);
        step(0, 1, 1, 0);
        drain();

        // Freeze mid-sequence
        step(1, 0, 1, 0);
        run_to(6, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0);
        chk("frz_lfsr", 32'(u_dut.r_lfsr), lfsr_val());
        run_to(m_T, 0);
        run_to(m_G + 3, 0);
        step(0, 1, 1, 0);
        drain();

        // N=0, saturation of the narrow counter
        n_val = 16'd0;
        step(1, 0, 1, 0);
        run_to(m_T, 0);
        run_to(m_G + 40, 0);
        step(0, 1, 1, 0);
        drain();

        // Reset mid-sequence
        n_val = 16'd1;
        step(1, 0, 1, 0);
        run_to(5, 0);
        step(0, 0, 1, 1);
        chk("midrst_rt", 32'(rt_a), 0);
        chk("midrst_lfsr", 32'(u_dut.r_lfsr), lfsr_val());
        drain();

        // Randomised runs
        for (int r = 0; r < 30; r++) begin
            n_val  = 16'($urandom_range(0, 3));
            tlen   = $urandom_range(1, 60);
            rat    = $urandom_range(1, 170);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 100) : -1;
            step(1, 0, 1, 0);
            for (int c = 1; c < 400 && m_run; c++)
                step(c < tlen, c >= rat, $urandom_range(0, 7) != 0, c == rst_at);
            drain();
        end

        @(negedge clk);
        #1;
        chk("left_lights", q_lights.size(), 0);
        chk("left_rt", q_rt.size(), 0);
        chk("left_fault", q_fault.size(), 0);
        chk("left_seq", q_seq.size(), 0);
        chk("left_hold", q_hold.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
